rf_wb_arbiter: RTL

Writeback arbiter that shares the single register-file write port between the ALU writeback path and the load/store unit (LSU) writeback path. It accepts write requests on two valid/ready channels and grants at most one per cycle. LSU has priority, bounded by a starvation limit for the ALU. The granted write is registered and driven onto the register file's `wen`/`waddr`/`wdata` port.

---
 rtl/rf_wb_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter
// Purpose  : Shares the single register-file write port between the ALU and
//            LSU writeback paths. LSU has priority; the ALU is guaranteed a
//            grant after STARVE_MAX consecutive LSU grants taken while it was
//            waiting. The granted write is registered onto rf_wen_o /
//            rf_waddr_o / rf_wdata_o.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            alu_valid_i/ready_o, alu_waddr_i, alu_wdata_i - ALU channel
//            lsu_valid_i/ready_o, lsu_waddr_i, lsu_wdata_i - LSU channel
//            rf_wen_o, rf_waddr_o, rf_wdata_o              - RF write port
//            starve_cnt_o       - consecutive ALU-starving LSU grants
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid_i,
  output logic        alu_ready_o,
  input  logic [4:0]  alu_waddr_i,
  input  logic [31:0] alu_wdata_i,
  input  logic        lsu_valid_i,
  output logic        lsu_ready_o,
  input  logic [4:0]  lsu_waddr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        rf_wen_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic [3:0]  starve_cnt_o
);

  localparam logic [3:0] c_STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]  starve_q, starve_d;
  logic        wen_q, wen_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;

  logic w_alu_grant;
  logic w_lsu_grant;

  // LSU wins unless the ALU has waited out its starvation budget.
  // Grants depend only on valids, the counter and reset, never on payload.
  always_comb begin
    w_lsu_grant = !rst && lsu_valid_i && (!alu_valid_i || (starve_q < c_STARVE_LIM));
    w_alu_grant = !rst && alu_valid_i && !w_lsu_grant;
  end

  always_comb begin
    starve_d = starve_q;
    wen_d    = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;

    if (w_alu_grant) begin
      waddr_d = alu_waddr_i;
      wdata_d = alu_wdata_i;
      // Writes to x0 complete the handshake but are dropped here.
      wen_d   = (alu_waddr_i != 5'd0);
    end else if (w_lsu_grant) begin
      waddr_d = lsu_waddr_i;
      wdata_d = lsu_wdata_i;
      wen_d   = (lsu_waddr_i != 5'd0);
    end

    // The counter only tracks LSU grants taken over a waiting ALU request.
    if (w_alu_grant || !alu_valid_i) begin
      starve_d = 4'd0;
    end else if (w_lsu_grant) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= 4'd0;
      wen_q    <= 1'b0;
      waddr_q  <= 5'd0;
      wdata_q  <= 32'd0;
    end else begin
      starve_q <= starve_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign alu_ready_o  = w_alu_grant;
  assign lsu_ready_o  = w_lsu_grant;
  assign rf_wen_o     = wen_q;
  assign rf_waddr_o   = waddr_q;
  assign rf_wdata_o   = wdata_q;
  assign starve_cnt_o = starve_q;

endmodule
`default_nettype wire
